add_accumulator: RTL

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

---
 rtl/add_accumulator_pkg.sv | 20 ++
 rtl/add_accumulator_adder.sv | 53 +++++
 rtl/add_accumulator.sv | 115 +++++++++++
 3 files changed

// File: rtl/add_accumulator_pkg.sv
// +--------------------------------------------------------------------+
// | add_accumulator_pkg: shared defaults and FSM state encoding.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package add_accumulator_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/add_accumulator_adder.sv
// +--------------------------------------------------------------------+
// | carry_bypass_adder: block carry-skip adder with signed overflow.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module carry_bypass_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NBLK = WIDTH / BLK;

  logic w_c_blk;
  logic w_c_rip;
  logic w_p_blk;
  logic w_a;
  logic w_b;

  // A block whose bits all propagate passes its carry-in straight through.
  always_comb begin
    sum_o   = '0;
    w_c_blk = cin_i;
    w_c_rip = 1'b0;
    w_p_blk = 1'b0;
    w_a     = 1'b0;
    w_b     = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      w_c_rip = w_c_blk;
      w_p_blk = 1'b1;
      for (int j = 0; j < BLK; j++) begin
        w_a                = a_i[k*BLK+j];
        w_b                = b_i[k*BLK+j];
        sum_o[k*BLK+j]     = w_a ^ w_b ^ w_c_rip;
        w_c_rip            = (w_a & w_b) | (w_c_rip & (w_a ^ w_b));
        w_p_blk            = w_p_blk & (w_a ^ w_b);
      end
      w_c_blk = w_p_blk ? w_c_blk : w_c_rip;
    end
    cout_o = w_c_blk;
    ovf_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

`default_nettype wire

// File: rtl/add_accumulator.sv
// +--------------------------------------------------------------------+
// | add_accumulator: sums a run of len operands, counts carries and    |
// | flags signed overflow. Rev 1.0                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module add_accumulator
  import add_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carry_cnt,
  output logic             out_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_accept;

  carry_bypass_adder #(
    .WIDTH (WIDTH),
    .BLK   (4)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (in_data),
    .cin_i (1'b0),
    .sum_o (w_sum),
    .cout_o(w_cout),
    .ovf_o (w_ovf)
  );

  assign in_ready      = (state_q == ACCUM);
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_sum       = acc_q;
  assign out_carry_cnt = cnt_q;
  assign out_ovf       = ovf_q;
  assign w_accept      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          acc_d = w_sum;
          if (w_cout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          ovf_d = ovf_q | w_ovf;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire
